// File: rtl/ram_bus_adapter.sv
// ram_bus_adapter
//   Request/response front end for a single-port block RAM with one-cycle
//   registered read data. Byte/half/word loads and stores are accepted on a
//   valid/ready request channel; accesses crossing a 32-bit word boundary are
//   issued as two RAM beats; illegal or out-of-range accesses are answered
//   with rsp_err without touching the RAM.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_*               request channel (addr, write, size, signed, wdata)
//   rsp_*               response channel (data, err), held until accepted
//   ram_addr/cs/wdata/wmask/wren  RAM command, all registered
//   ram_rdata           RAM read data, valid the cycle after ram_cs
module ram_bus_adapter #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wmask,
    output logic                  ram_wren,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPT, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic                  sext_q, sext_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  split_q, split_d;
    logic [31:0]           lo_buf_q, lo_buf_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_cs_q, ram_cs_d;
    logic                  ram_wren_q, ram_wren_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic [3:0]            ram_wmask_q, ram_wmask_d;

    // Incoming request decode
    logic [2:0]  req_nbytes;
    logic [32:0] req_last;
    logic        req_err;
    logic        req_split;

    always_comb begin
        case (req_size)
            2'd0:    req_nbytes = 3'd1;
            2'd1:    req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        // 33-bit sum so a request near 2^32 cannot wrap back into range
        req_last  = {1'b0, req_addr} + {30'b0, req_nbytes} - 33'd1;
        req_err   = (req_size == 2'd3) || (req_last >= (33'd1 << ADDR_WIDTH));
        req_split = ({2'b00, req_addr[1:0]} + {1'b0, req_nbytes}) > 4'd4;
    end

    // N contiguous lanes starting at lane 'off'. Bits [3:0] are the lanes of
    // the first word, bits [7:4] the lanes that spill into the next word.
    function automatic logic [7:0] lane_span(input logic [2:0] nbytes, input logic [1:0] off);
        lane_span = ((8'd1 << nbytes) - 8'd1) << off;
    endfunction

    logic [7:0]  lanes;
    logic [5:0]  off_bits;
    logic [63:0] pair;
    logic [31:0] aligned;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        nbytes_d    = nbytes_q;
        sext_d      = sext_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        lo_buf_d    = lo_buf_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ram_addr_d  = '0;
        ram_cs_d    = 1'b0;
        ram_wren_d  = 1'b0;
        ram_wdata_d = '0;
        ram_wmask_d = '0;
        lanes       = '0;

        off_bits = {1'b0, addr_q[1:0], 3'b000};
        // Beat 1 is only meaningful for split accesses; otherwise the single
        // beat arrives on ram_rdata and the upper word is zero.
        pair    = {split_q ? ram_rdata : 32'h0, split_q ? lo_buf_q : ram_rdata};
        aligned = 32'(pair >> off_bits);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[ADDR_WIDTH-1:0];
                    write_d  = req_write;
                    nbytes_d = req_nbytes;
                    sext_d   = req_signed;
                    wdata_d  = req_wdata;
                    split_d  = req_split;
                    if (req_err) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        // Outputs are registered, so the ISSUE0 command is
                        // prepared here from the live request fields.
                        lanes       = lane_span(req_nbytes, req_addr[1:0]);
                        rsp_err_d   = 1'b0;
                        ram_cs_d    = 1'b1;
                        ram_wren_d  = req_write;
                        ram_addr_d  = req_addr[ADDR_WIDTH-1:0];
                        ram_wdata_d = req_wdata;
                        ram_wmask_d = lanes[3:0];
                        state_d     = ISSUE0;
                    end
                end
            end
            ISSUE0: begin
                if (split_q) begin
                    lanes       = lane_span(nbytes_q, addr_q[1:0]);
                    ram_cs_d    = 1'b1;
                    ram_wren_d  = write_q;
                    ram_addr_d  = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
                    ram_wdata_d = wdata_q >> (6'd32 - off_bits);
                    ram_wmask_d = lanes[7:4];
                    state_d     = ISSUE1;
                end else begin
                    state_d = CAPT;
                end
            end
            ISSUE1: begin
                lo_buf_d = ram_rdata;
                state_d  = CAPT;
            end
            CAPT: begin
                case (nbytes_q)
                    3'd1:    rsp_data_d = {{24{sext_q & aligned[7]}}, aligned[7:0]};
                    3'd2:    rsp_data_d = {{16{sext_q & aligned[15]}}, aligned[15:0]};
                    default: rsp_data_d = aligned;
                endcase
                if (write_q) begin
                    rsp_data_d = '0;
                end
                rsp_err_d = 1'b0;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            nbytes_q    <= '0;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            lo_buf_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_cs_q    <= 1'b0;
            ram_wren_q  <= 1'b0;
            ram_wdata_q <= '0;
            ram_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            nbytes_q    <= nbytes_d;
            sext_q      <= sext_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            lo_buf_q    <= lo_buf_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_cs_q    <= ram_cs_d;
            ram_wren_q  <= ram_wren_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wmask_q <= ram_wmask_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_cs    = ram_cs_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wmask = ram_wmask_q;
    assign ram_wren  = ram_wren_q;

endmodule

// File: doc/ram_bus_adapter.md
# ram_bus_adapter

Request/response front end for the single-port block RAM. It accepts byte, halfword and word loads and stores on a valid/ready request channel, and drives the RAM's address, chip-select, write-data, lane-mask and write-enable ports. It consumes the RAM's one-cycle-latency registered read data and returns aligned, sign- or zero-extended results on a valid/ready response channel. Accesses that straddle a 32-bit word boundary are split into two RAM beats; out-of-range or illegal accesses are rejected without touching the RAM.

## Interface
- ADDR_WIDTH, 12, byte-address width of the RAM port; legal addresses are 0 .. 2^ADDR_WIDTH-1
- clock  in  1  global clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  adapter can accept a request (high only in IDLE)
- req_addr  in  32  byte address
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads only: sign-extend byte/half
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  load result; 0 for stores and errors
- rsp_err  out  1  access rejected
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_cs  out  1  RAM chip select
- ram_wdata  out  32  right-justified; the RAM shifts it by ram_addr[1:0]
- ram_wmask  out  4  byte-lane mask in final lane positions (bit i = lane i)
- ram_wren  out  1  RAM write enable
- ram_rdata  in  32  RAM read data, valid the cycle after an access with ram_cs=1

## Operation
- Latched request fields: A = addr, W = write, N = bytes (1/2/4), S = signed, D = wdata; off = A[1:0]; split = (off + N > 4).
- Error if req_size == 3, or A + N - 1 >= 2^ADDR_WIDTH (covers the top-of-RAM crossing).
- States: IDLE, ISSUE0, ISSUE1, CAPT, RESP.
  - IDLE: req_ready=1, ram_cs=0. On req_valid, latch the fields. Go to RESP with rsp_err=1 and rsp_data=0 on error; otherwise go to ISSUE0.
  - ISSUE0: ram_cs=1, ram_wren=W, ram_addr=A[ADDR_WIDTH-1:0], ram_wdata=D, ram_wmask=(((1<<N)-1)<<off)[3:0]. Next state is ISSUE1 if split, else CAPT.
  - ISSUE1: ram_cs=1, ram_wren=W, ram_addr={A[AW-1:2]+1, 2'b00}, ram_wdata=D >> 8*(4-off), ram_wmask=((1<<N)-1) >> (4-off). Capture ram_rdata (beat 0) into lo_buf. Next state is CAPT.
  - CAPT: ram_cs=0. The last beat is on ram_rdata. Form the 64-bit value {beat1, beat0}, where beat1=0 when not split, and shift it right by 8*off. Keep the low N bytes; sign-extend if S && N<4, else zero-extend. Register the result into rsp_data (0 if W). Next state is RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_valid && rsp_ready, then go to IDLE.
- Outside ISSUE0/ISSUE1: ram_cs, ram_wren and ram_wmask are 0. ram_addr and ram_wdata are don't-care but driven to 0.
- Stores always produce a response (rsp_err=0, rsp_data=0).
- At most one request is outstanding; no pipelining across requests.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; ram_cs=0; ram_wren=0; ram_wmask=0; ram_addr=0; ram_wdata=0; lo_buf=0.
- Request accepted at cycle T: ISSUE0 at T+1. rsp_valid at T+3 (aligned) or T+4 (split). Error: rsp_valid at T+1, and ram_cs is never asserted.
- Minimum request-to-request spacing: 4 cycles aligned, 5 split, 2 error. rsp_ready held high gives IDLE on the cycle after the RESP handshake.
- Reset mid-operation aborts at the next edge with no response. A split store interrupted after ISSUE0 leaves only beat 0 written; this is accepted behaviour.
- req_valid with req_ready=0 is ignored; the requester must hold it.

## Test plan
- Store word 0x80FF7F01 @0x100, then load word @0x100 -> rsp_data=0x80FF7F01, rsp_valid exactly 3 cycles after acceptance, RAM saw ram_wmask=4'hF.
- Byte loads after the above: @0x101 signed -> 0x0000007F; @0x103 signed -> 0xFFFFFF80; @0x103 unsigned -> 0x00000080; half @0x102 signed -> 0xFFFF80FF.
- Split store word 0xAABBCCDD @0x202 -> beat0 addr 0x202 mask 4'hC, beat1 addr 0x204 mask 4'h3 wdata 0x0000AABB. Word @0x200 low half unchanged. Load word @0x202 -> 0xAABBCCDD at T+4.
- Errors (ADDR_WIDTH=12): load @0x1000 -> rsp_err=1, rsp_data=0 at T+1, ram_cs never high. Word @0xFFE -> rsp_err=1. req_size=3 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stable, req_ready=0, no ram_cs; on release, IDLE the next cycle.
- Assert reset during ISSUE1 of a split store -> no response; all outputs at reset values the next cycle; the next request completes normally.
